msec_timer_ctrl: RTL and testbench
==================================

Name: msec_timer_ctrl

Overview:
Controller that sequences a millisecond down-counter running from the 4 MHz system clock. Converts clk_4m into 1 ms ticks with a prescaler and loads, runs, pauses, stops and expires a CNT_W-bit millisecond count. Presents remaining time on Q. Sits beside the msec counter datapath as its start/stop/expiry scheduler for higher-level control logic.

Parameters:
TICK_DIV, 4000, clk_4m cycles per 1 ms tick (4 MHz / 1 kHz); legal range ≥ 2.
CNT_W, 4, width of millisecond count, load value and Q.

Ports:
clk_4m  input  1  4 MHz system clock; all state on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  1-cycle request: latch load_val and begin countdown.
stop  input  1  1-cycle request: abort countdown, return to IDLE.
pause  input  1  level; while high in RUN, countdown is frozen.
load_val  input  CNT_W  initial millisecond count, sampled only when start is accepted.
Q  output  CNT_W  remaining milliseconds.
tick  output  1  1-cycle pulse on each 1 ms decrement.
done  output  1  1-cycle pulse on expiry.
busy  output  1  high in RUN or HOLD.

Behaviour:
- All outputs registered. Reset (rst=1 at edge): state=IDLE, Q=0, prescaler=0, reload register=0, tick=0, done=0, busy=0. Reset overrides every other input, including mid-countdown.
- States: IDLE, RUN, HOLD.
- Input priority each cycle: rst > stop > start > pause.
- IDLE:
  - start with load_val≠0: Q<=load_val, reload<=load_val, prescaler<=0, go to RUN. busy is high from the next cycle.
  - start with load_val=0: stay in IDLE; done pulses on the next cycle; Q stays 0.
- RUN:
  - pause=0: prescaler increments each cycle.
  - When prescaler=TICK_DIV-1: prescaler<=0, tick=1, Q<=Q-1.
  - If Q was 1 at that edge: done=1 in the same cycle as tick, Q becomes 0, go to IDLE.
  - pause=1: go to HOLD; prescaler and Q unchanged; no tick that cycle, even at the terminal prescaler count.
- HOLD: prescaler and Q frozen. pause=0 → RUN, prescaler resumes from its held value. busy stays high.
- stop in RUN or HOLD: go to IDLE, Q<=0, prescaler<=0, no done, no tick. stop in IDLE has no effect.
- start in RUN or HOLD: restart. Q<=load_val, reload<=load_val, prescaler<=0, state RUN, no done for the aborted run. Restart with load_val=0 behaves as start-in-IDLE with zero: done pulses, state IDLE.
- Latency: start accepted at edge N → Q=load_val after edge N; first tick after edge N+TICK_DIV; expiry after edge N+load_val×TICK_DIV (no pause).
- Q never wraps below 0. Prescaler width is ceil(log2(TICK_DIV)). Decrement is CNT_W-bit unsigned.

Optional Feature:
MSEC_TIMER_AUTO_RELOAD_EN.
- Defined: on expiry, done pulses, Q<=reload (not 0), prescaler<=0, state stays RUN, busy stays high. Periodic done every reload×TICK_DIV cycles until stop, rst or a new start. If reload=0, behaviour is identical to undefined.
- Undefined: expiry returns to IDLE as described in Behaviour; the reload register may be omitted.

Test Plan:
- Basic (TICK_DIV=4, CNT_W=4): rst, then start with load_val=3 → Q=3 after start edge; ticks at +4/+8/+12 cycles; Q 2,1,0; done coincides with third tick; busy low afterwards.
- Pause: load_val=2, raise pause at cycle +2 for 5 cycles → Q holds at 2, no tick during pause; first tick at +9, done at +13.
- Stop/restart: load_val=5, stop at +6 → Q=0, busy=0, no done. Then start with load_val=1 during RUN of a prior load_val=9 → Q=1, done 4 cycles later.
- Priority/zero: stop and start in the same cycle → IDLE, Q=0. start with load_val=0 → done pulse next cycle, busy never asserted.
- Reset mid-run: load_val=15, assert rst at +7 → all outputs 0 next cycle; later start with load_val=15 → 15 ticks, Q reaches 0 with no wrap to 15.
- With MSEC_TIMER_AUTO_RELOAD_EN: load_val=2 → done at +8, +16, +24; Q sequence 2,1,2,1,…; stop ends the sequence.

Source files
------------

// File: rtl/msec_timer_ctrl_if.sv
// Control/status bundle between higher-level control logic and msec_timer_ctrl.
// Parameterised by CNT_W so the count, load value and Q widths always agree.
interface msec_timer_ctrl_if #(
  parameter int CNT_W = 4
);
  // Handshake: start and stop are single-cycle requests that the timer always
  // accepts on the edge they are sampled (no ready), with rst > stop > start > pause.
  // pause is a level. tick and done are registered single-cycle pulses; Q and busy
  // are registered levels that change only on the rising clock edge.
  logic             start;
  logic             stop;
  logic             pause;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] Q;
  logic             tick;
  logic             done;
  logic             busy;

  modport master (
    output start,
    output stop,
    output pause,
    output load_val,
    input  Q,
    input  tick,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  stop,
    input  pause,
    input  load_val,
    output Q,
    output tick,
    output done,
    output busy
  );
endinterface

// File: rtl/msec_timer_ctrl.sv
// Millisecond down-count scheduler: prescales clk_4m into 1 ms ticks and runs an
// IDLE/RUN/HOLD countdown. Define MSEC_TIMER_AUTO_RELOAD_EN for periodic reload on expiry.
module msec_timer_ctrl #(
  parameter int TICK_DIV = 4000,
  parameter int CNT_W    = 4
) (
  input  logic               clk_4m,
  input  logic               rst,
  msec_timer_ctrl_if.slave   tmr,
  output logic [1:0]         dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] q_q, q_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q;
`ifdef MSEC_TIMER_AUTO_RELOAD_EN
  logic [CNT_W-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge clk_4m) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MSEC_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= (state_d != ST_IDLE);
`ifdef MSEC_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    pre_d    = pre_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
`ifdef MSEC_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (tmr.stop) begin
      // stop outranks start even in IDLE, so a simultaneous start is dropped.
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        q_d     = '0;
        pre_d   = '0;
      end
    end else if (tmr.start) begin
      pre_d = '0;
`ifdef MSEC_TIMER_AUTO_RELOAD_EN
      reload_d = tmr.load_val;
`endif
      if (tmr.load_val == '0) begin
        state_d = ST_IDLE;
        q_d     = '0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        q_d     = tmr.load_val;
      end
    end else if (state_q != ST_IDLE) begin
      if (tmr.pause) begin
        state_d = ST_HOLD;
      end else begin
        // Leaving HOLD counts as a running cycle: the prescaler advances this edge.
        state_d = ST_RUN;
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
          q_d    = q_q - CNT_W'(1);
          if (q_q == CNT_W'(1)) begin
            done_d = 1'b1;
`ifdef MSEC_TIMER_AUTO_RELOAD_EN
            if (reload_q != '0) begin
              q_d = reload_q;
            end else begin
              state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    end
  end

  assign tmr.Q    = q_q;
  assign tmr.tick = tick_q;
  assign tmr.done = done_q;
  assign tmr.busy = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_msec_timer_ctrl.sv
// Randomised scoreboard bench for msec_timer_ctrl against a cycles-to-next-tick
// reference model; directed test-plan sequences run first, then random traffic.
module tb_msec_timer_ctrl;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 4;
  localparam int EW       = CNT_W + 3;

  logic       clk_4m = 1'b0;
  logic       rst    = 1'b1;
  logic [1:0] dbg_state;

  msec_timer_ctrl_if #(.CNT_W(CNT_W)) tmr ();

  msec_timer_ctrl #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_4m    (clk_4m),
    .rst       (rst),
    .tmr       (tmr),
    .dbg_state (dbg_state)
  );

  always #5 clk_4m = ~clk_4m;

  // Scoreboard: {Q, tick, done, busy} expected after each edge.
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: remaining ms, clock cycles left until the next ms elapses.
  bit m_active = 1'b0;
  int m_ms     = 0;
  int m_cyc    = 0;
  int m_period = 0;

  task automatic step(input bit r, input bit sp, input bit st, input bit pa, input int lv);
    bit tk;
    bit dn;
    logic [EW-1:0] e;
    @(negedge clk_4m);
    rst          = r;
    tmr.stop     = sp;
    tmr.start    = st;
    tmr.pause    = pa;
    tmr.load_val = CNT_W'(lv);
    tk = 1'b0;
    dn = 1'b0;
    if (r) begin
      m_active = 1'b0; m_ms = 0; m_cyc = 0; m_period = 0;
    end else if (sp) begin
      if (m_active) begin
        m_active = 1'b0; m_ms = 0;
      end
    end else if (st) begin
      m_period = lv;
      if (lv == 0) begin
        m_active = 1'b0; m_ms = 0; dn = 1'b1;
      end else begin
        m_active = 1'b1; m_ms = lv; m_cyc = TICK_DIV;
      end
    end else if (m_active && !pa) begin
      m_cyc = m_cyc - 1;
      if (m_cyc == 0) begin
        tk    = 1'b1;
        m_ms  = m_ms - 1;
        m_cyc = TICK_DIV;
        if (m_ms == 0) begin
          dn = 1'b1;
`ifdef MSEC_TIMER_AUTO_RELOAD_EN
          if (m_period != 0) m_ms = m_period;
          else m_active = 1'b0;
`else
          m_active = 1'b0;
`endif
        end
      end
    end
    e = {CNT_W'(m_ms), tk, dn, m_active};
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 15)));
  endtask

  task automatic go(input int lv);
    step(1'b0, 1'b0, 1'b1, 1'b0, lv);
  endtask

  // Monitor: every edge that has a pending expectation is compared.
  logic [EW-1:0] mon_e;
  logic [EW-1:0] mon_got;
  always @(posedge clk_4m) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_got = {tmr.Q, tmr.tick, tmr.done, tmr.busy};
      n_cmp++;
      if (mon_got !== mon_e) begin
        n_bad++;
        $display("FAIL cyc%0d q_tick_done_busy got Q=%0d t=%b d=%b b=%b expected Q=%0d t=%b d=%b b=%b",
                 cyc, mon_got[EW-1:3], mon_got[2], mon_got[1], mon_got[0],
                 mon_e[EW-1:3], mon_e[2], mon_e[1], mon_e[0]);
      end
      n_cmp++;
      if ((dbg_state != 2'd0) !== mon_e[0]) begin
        n_bad++;
        $display("FAIL cyc%0d dbg_state_active got state=%0d expected active=%b", cyc, dbg_state, mon_e[0]);
      end
    end
  end

  initial begin
    bit pa;
    tmr.start    = 1'b0;
    tmr.stop     = 1'b0;
    tmr.pause    = 1'b0;
    tmr.load_val = '0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 7);
    idle(2);
    // Basic countdown of 3.
    go(3); idle(14);
    // Pause for 5 cycles starting at +2.
    go(2); idle(1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 3);
    idle(10);
    // Stop mid-run, then restart during a long run.
    go(5); idle(5); step(1'b0, 1'b1, 1'b0, 1'b0, 0); idle(3);
    go(9); idle(5); go(1); idle(6);
    // Simultaneous stop/start, in IDLE and during RUN.
    step(1'b0, 1'b1, 1'b1, 1'b0, 7); idle(2);
    go(4); idle(3); step(1'b0, 1'b1, 1'b1, 1'b0, 6); idle(2);
    // Zero loads, from IDLE and as a restart.
    go(0); idle(3);
    go(6); idle(2); go(0); idle(3);
    // Stop while held, start while paused.
    go(3); step(1'b0, 1'b0, 1'b0, 1'b1, 0); step(1'b0, 1'b1, 1'b0, 1'b1, 0); idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 2); step(1'b0, 1'b0, 1'b0, 1'b1, 0); idle(10);
    // Pause exactly at the terminal prescaler count.
    go(1); idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle(4);
    // Reset mid-run, then a full 15 ms count.
    go(15); idle(6); step(1'b1, 1'b0, 1'b0, 1'b0, 0); idle(2);
    go(15); idle(64);
    // Expiry sequence (periodic when auto-reload is built in), then stop.
    go(2); idle(26); step(1'b0, 1'b1, 1'b0, 1'b0, 0); idle(3);

    pa = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit r, sp, st;
      r  = ($urandom_range(0, 299) == 0);
      sp = ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) pa = ~pa;
      step(r, sp, st, pa, int'($urandom_range(0, 15)));
    end
    idle(2);

    repeat (2) @(posedge clk_4m);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
